comp_result_monitor: RTL

//   Downstream consumer of simple_comparator's 1-bit res (1 = input_a equals input_b).

---
 rtl/comp_result_monitor.sv | 109 ++++++++++
 1 files changed

// File: rtl/comp_result_monitor.sv
// Windowed match counter / mismatch-run tracker for comparator results; report 1 cycle after last sample,
// sample input stalls while a report waits for rpt_ready. STICKY_ALARM_EN latches alarm until clear/rst.
module comp_result_monitor #(
  parameter int WINDOW    = 16,
  parameter int RUN_LIMIT = 4,
  localparam int CNT_W    = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res,
  input  logic             clear,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_match,
  output logic [CNT_W-1:0] rpt_max_run,
  output logic             alarm
);

  typedef enum logic {COLLECT, REPORT} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] cur_run_q;
  logic [CNT_W-1:0] max_run_q;
  logic             rpt_valid_q;
  logic [CNT_W-1:0] rpt_match_q;
  logic [CNT_W-1:0] rpt_max_run_q;
  logic             alarm_q;

  logic             accept;
  logic             last_sample;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] max_upd_d;
  logic [CNT_W-1:0] match_cnt_d;
  logic [CNT_W-1:0] max_run_d;
  logic [CNT_W-1:0] cur_run_d;
  logic             alarm_hit;
  logic             alarm_d;

  assign res_ready   = (state_q == COLLECT);
  assign accept      = res_valid & res_ready;
  assign last_sample = (sample_cnt_q == CNT_W'(WINDOW - 1));

  // Run length saturates so a very long outage cannot wrap back below the alarm limit.
  assign run_inc     = (cur_run_q == {CNT_W{1'b1}}) ? cur_run_q : cur_run_q + CNT_W'(1);
  assign max_upd_d   = (run_inc > max_run_q) ? run_inc : max_run_q;
  assign match_cnt_d = match_cnt_q + CNT_W'(res);
  assign max_run_d   = res ? max_run_q : max_upd_d;
  assign cur_run_d   = accept ? (res ? '0 : run_inc) : cur_run_q;
  assign alarm_hit   = (cur_run_d >= CNT_W'(RUN_LIMIT));

`ifdef STICKY_ALARM_EN
  assign alarm_d = alarm_q | alarm_hit;
`else
  assign alarm_d = alarm_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q       <= COLLECT;
      sample_cnt_q  <= '0;
      match_cnt_q   <= '0;
      cur_run_q     <= '0;
      max_run_q     <= '0;
      rpt_valid_q   <= 1'b0;
      rpt_match_q   <= '0;
      rpt_max_run_q <= '0;
      alarm_q       <= 1'b0;
    end else begin
      cur_run_q <= cur_run_d;
      alarm_q   <= alarm_d;
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (last_sample) begin
              rpt_match_q   <= match_cnt_d;
              rpt_max_run_q <= max_run_d;
              rpt_valid_q   <= 1'b1;
              state_q       <= REPORT;
              sample_cnt_q  <= '0;
              match_cnt_q   <= '0;
              max_run_q     <= '0;
            end else begin
              sample_cnt_q  <= sample_cnt_q + CNT_W'(1);
              match_cnt_q   <= match_cnt_d;
              max_run_q     <= max_run_d;
            end
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            rpt_valid_q <= 1'b0;
            state_q     <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign rpt_valid   = rpt_valid_q;
  assign rpt_match   = rpt_match_q;
  assign rpt_max_run = rpt_max_run_q;
  assign alarm       = alarm_q;

endmodule
